bids_round_ctrl: RTL

BIDS_ROUND_CTRL -- requirements
Module: bids_round_ctrl

---
 rtl/bids_round_ctrl_if.sv | 27 ++
 rtl/bids_round_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bids_round_ctrl_if.sv
// Bus bundle for bids_round_ctrl: command port, round request, bidder handshake and status.
interface bids_round_ctrl_if;
    logic        cmd_valid;
    logic [3:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        start;
    logic [2:0]  bid_req;
    logic        bid_done;
    logic [2:0]  bid_gnt;
    logic        locked;
    logic        round_active;
    logic        round_over;
    logic [1:0]  err;
    logic [2:0]  mask;
    logic [31:0] bid_cost;
    logic [31:0] timer_cfg;

    modport master (
        output cmd_valid, cmd_op, cmd_data, start, bid_req, bid_done,
        input  bid_gnt, locked, round_active, round_over, err, mask, bid_cost, timer_cfg
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, start, bid_req, bid_done,
        output bid_gnt, locked, round_active, round_over, err, mask, bid_cost, timer_cfg
    );
endinterface

// File: rtl/bids_round_ctrl.sv
// Auction round controller: key lock, timed rounds, round-robin grant to three bidders {X,Y,Z}.
// Optional grant watchdog compiled in with BIDS_GNT_WATCHDOG_EN.
module bids_round_ctrl #(
    parameter logic [31:0] UnlockKey = 32'h0F0F_0F0F,
    parameter logic [31:0] DefTimer  = 32'h0000_000F
) (
    input logic              clk,
    input logic              reset_n,
    bids_round_ctrl_if.slave bus_io
);

    localparam logic [3:0] OpNoOp      = 4'd0;
    localparam logic [3:0] OpUnlock    = 4'd1;
    localparam logic [3:0] OpLock      = 4'd2;
    localparam logic [3:0] OpSetMask   = 4'd6;
    localparam logic [3:0] OpSetTimer  = 4'd7;
    localparam logic [3:0] OpBidCharge = 4'd8;

    localparam logic [1:0] ErrNone    = 2'b00;
    localparam logic [1:0] ErrBadKey  = 2'b01;
    localparam logic [1:0] ErrIllegal = 2'b10;
    localparam logic [1:0] ErrStart   = 2'b11;

    typedef enum logic [2:0] {StUnlocked, StLocked, StRound, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] key_q, key_d;
    logic [2:0]  mask_q, mask_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] cost_q, cost_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  rr_q, rr_d;
    logic [1:0]  err_q, err_d;
    logic [2:0]  gnt_q, gnt_d;
`ifdef BIDS_GNT_WATCHDOG_EN
    logic [4:0]  wd_q, wd_d;
`endif

    logic        cmd_act;
    logic [31:0] cnt_dec;
    logic [2:0]  elig;
    logic        found;
    logic [1:0]  pick;
    logic [2:0]  cand;

    always_comb begin
        cmd_act = bus_io.cmd_valid && (bus_io.cmd_op != OpNoOp);
        cnt_dec = (cnt_q == 32'd0) ? 32'd0 : cnt_q - 32'd1;
        elig    = bus_io.bid_req & mask_q;

        // rr_q holds the index (0=X, 1=Y, 2=Z) searched first; bit for index i is elig[2-i].
        found = 1'b0;
        pick  = rr_q;
        cand  = 3'd0;
        for (int k = 0; k < 3; k++) begin
            cand = {1'b0, rr_q} + 3'(k);
            if (cand >= 3'd3) cand = cand - 3'd3;
            if (!found && ((elig & (3'b100 >> cand)) != 3'b000)) begin
                found = 1'b1;
                pick  = cand[1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        mask_d  = mask_q;
        timer_d = timer_q;
        cost_d  = cost_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        err_d   = err_q;
        gnt_d   = gnt_q;
`ifdef BIDS_GNT_WATCHDOG_EN
        wd_d    = wd_q;
`endif

        unique case (state_q)
            StUnlocked: begin
                if (bus_io.start && !cmd_act) err_d = ErrStart;
                if (bus_io.cmd_valid) begin
                    case (bus_io.cmd_op)
                        OpNoOp:      ;
                        OpSetMask:   begin mask_d  = bus_io.cmd_data[2:0]; err_d = ErrNone; end
                        OpSetTimer:  begin timer_d = bus_io.cmd_data;      err_d = ErrNone; end
                        OpBidCharge: begin cost_d  = bus_io.cmd_data;      err_d = ErrNone; end
                        OpLock: begin
                            key_d   = bus_io.cmd_data;
                            err_d   = ErrNone;
                            state_d = StLocked;
                        end
                        default:     err_d = ErrIllegal;
                    endcase
                end
            end
            StLocked: begin
                if (cmd_act) begin
                    if (bus_io.cmd_op != OpUnlock) begin
                        err_d = ErrIllegal;
                    end else if (bus_io.cmd_data == key_q) begin
                        err_d   = ErrNone;
                        state_d = StUnlocked;
                    end else begin
                        err_d = ErrBadKey;
                    end
                end else if (bus_io.start) begin
                    cnt_d   = timer_q;
                    state_d = (timer_q == 32'd0) ? StDone : StRound;
                end
            end
            StRound: begin
                cnt_d = cnt_dec;
                if (cmd_act) err_d = ErrIllegal;
                // Round expires on the cycle the counter would reach zero.
                if (cnt_dec == 32'd0 || !bus_io.start) begin
                    state_d = StDone;
                end else if (found) begin
                    gnt_d   = 3'b100 >> pick;
                    rr_d    = (pick == 2'd2) ? 2'd0 : pick + 2'd1;
                    state_d = StWait;
`ifdef BIDS_GNT_WATCHDOG_EN
                    wd_d    = 5'd0;
`endif
                end
            end
            StWait: begin
                cnt_d = cnt_dec;
                if (cmd_act) err_d = ErrIllegal;
                if (bus_io.bid_done) begin
                    gnt_d   = 3'b000;
                    state_d = (cnt_dec == 32'd0 || !bus_io.start) ? StDone : StRound;
                end
`ifdef BIDS_GNT_WATCHDOG_EN
                else if (wd_q == 5'd15) begin
                    gnt_d   = 3'b000;
                    err_d   = ErrIllegal;
                    state_d = StRound;
                end else begin
                    wd_d = wd_q + 5'd1;
                end
`endif
            end
            StDone: begin
                if (cmd_act) err_d = ErrIllegal;
                state_d = StLocked;
            end
            default: state_d = StUnlocked;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StUnlocked;
            key_q   <= UnlockKey;
            mask_q  <= 3'b111;
            timer_q <= DefTimer;
            cost_q  <= 32'd1;
            cnt_q   <= 32'd0;
            rr_q    <= 2'd0;
            err_q   <= ErrNone;
            gnt_q   <= 3'b000;
`ifdef BIDS_GNT_WATCHDOG_EN
            wd_q    <= 5'd0;
`endif
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            mask_q  <= mask_d;
            timer_q <= timer_d;
            cost_q  <= cost_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
            gnt_q   <= gnt_d;
`ifdef BIDS_GNT_WATCHDOG_EN
            wd_q    <= wd_d;
`endif
        end
    end

    assign bus_io.bid_gnt      = gnt_q;
    assign bus_io.locked       = (state_q != StUnlocked);
    assign bus_io.round_active = (state_q == StRound) || (state_q == StWait);
    assign bus_io.round_over   = (state_q == StDone);
    assign bus_io.err          = err_q;
    assign bus_io.mask         = mask_q;
    assign bus_io.bid_cost     = cost_q;
    assign bus_io.timer_cfg    = timer_q;

endmodule
